rom_port_arbiter: RTL and testbench

Shares the single instruction-ROM port between the fetch requester (pre-IF PC generator) and a data-side requester (LSU/debug access to instruction memory). It sits between the pre-IF/IF stages, the data path, and the ROM. It grants one address-phase request per cycle and tracks in-order outstanding transactions in an owner FIFO. Read/write responses are routed back to the issuing master, and fetch responses are discarded after a pipeline redirect.

---
 rtl/rom_port_arbiter.sv | 113 +++++++++++
 tb/tb_rom_port_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares the instruction-ROM port between the fetch side and
// the data side. One address phase is granted per cycle. An in-order owner FIFO
// routes each response back to the master that issued it. Fetch responses that
// are outstanding at a redirect are marked as killed and are then dropped.
module rom_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [DATA_W-1:0] f_addr,
    output logic              f_addr_ok,
    output logic              f_data_ok,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              f_cancel,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_wstrb,
    input  logic [DATA_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_addr_ok,
    output logic              d_data_ok,
    output logic [DATA_W-1:0] d_rdata,
    output logic              rom_req,
    output logic              rom_we,
    output logic [3:0]        rom_wstrb,
    output logic [DATA_W-1:0] rom_addr,
    output logic [DATA_W-1:0] rom_wdata,
    input  logic              rom_addr_ok,
    input  logic              rom_data_ok,
    input  logic [DATA_W-1:0] rom_rdata
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int ST_W  = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [ST_W-1:0]  ST_MAX_C = ST_W'(STARVE_MAX);

    // Owner FIFO slots: own_f=1 marks a fetch entry, kill marks a dropped fetch.
    logic [DEPTH-1:0] own_f;
    logic [DEPTH-1:0] kill;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [ST_W-1:0]  starve_cnt;

    logic space;
    logic f_win;
    logic accept;
    logic pop;

    // Address phase: pick the winner and drive the ROM request.
    // A free slot also exists when the head retires in this same cycle.
    always_comb begin
        space     = (count < DEPTH_C) || rom_data_ok;
        f_win     = f_req && (!d_req || (starve_cnt == ST_MAX_C));
        rom_req   = (f_req || d_req) && space;
        accept    = rom_req && rom_addr_ok;
        f_addr_ok = accept && f_win;
        d_addr_ok = accept && !f_win;
        rom_addr  = f_win ? f_addr : d_addr;
        rom_we    = !f_win && d_we;
        rom_wstrb = f_win ? 4'b0000 : d_wstrb;
        rom_wdata = f_win ? '0 : d_wdata;
    end

    // Response phase: retire the FIFO head and steer data_ok to its owner.
    // A cancel in the same cycle also drops the fetch response that is popped.
    always_comb begin
        pop       = rom_data_ok && (count != '0);
        f_data_ok = pop && own_f[head] && !kill[head] && !f_cancel;
        d_data_ok = pop && !own_f[head];
        f_rdata   = rom_rdata;
        d_rdata   = rom_rdata;
    end

    // Owner FIFO bookkeeping: pointers, occupancy, owner and kill bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            own_f <= '0;
            kill  <= '0;
        end else begin
            if (pop)
                head <= head + 1'b1;
            if (accept)
                tail <= tail + 1'b1;
            count <= count + CNT_W'(accept) - CNT_W'(pop);
            if (f_cancel)
                kill <= kill | own_f;
            if (accept) begin
                own_f[tail] <= f_win;
                kill[tail]  <= f_win && f_cancel;
            end
        end
    end

    // Starvation counter: counts data-side wins while fetch is kept waiting.
    always_ff @(posedge clk) begin
        if (rst)
            starve_cnt <= '0;
        else if (!f_req || f_addr_ok)
            starve_cnt <= '0;
        else if (d_addr_ok && (starve_cnt != ST_MAX_C))
            starve_cnt <= starve_cnt + 1'b1;
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: directed stimulus for rom_port_arbiter. A queue-based
// model predicts every output on each cycle, and literal checks at key points
// fix the expected behaviour of both the model and the design.
module tb_rom_port_arbiter;

    localparam int DATA_W     = 32;
    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              f_req;
    logic [DATA_W-1:0] f_addr;
    logic              f_addr_ok;
    logic              f_data_ok;
    logic [DATA_W-1:0] f_rdata;
    logic              f_cancel;
    logic              d_req;
    logic              d_we;
    logic [3:0]        d_wstrb;
    logic [DATA_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_addr_ok;
    logic              d_data_ok;
    logic [DATA_W-1:0] d_rdata;
    logic              rom_req;
    logic              rom_we;
    logic [3:0]        rom_wstrb;
    logic [DATA_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_wdata;
    logic              rom_addr_ok;
    logic              rom_data_ok;
    logic [DATA_W-1:0] rom_rdata;

    rom_port_arbiter #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .f_req      (f_req),
        .f_addr     (f_addr),
        .f_addr_ok  (f_addr_ok),
        .f_data_ok  (f_data_ok),
        .f_rdata    (f_rdata),
        .f_cancel   (f_cancel),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_wstrb    (d_wstrb),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_addr_ok  (d_addr_ok),
        .d_data_ok  (d_data_ok),
        .d_rdata    (d_rdata),
        .rom_req    (rom_req),
        .rom_we     (rom_we),
        .rom_wstrb  (rom_wstrb),
        .rom_addr   (rom_addr),
        .rom_wdata  (rom_wdata),
        .rom_addr_ok(rom_addr_ok),
        .rom_data_ok(rom_data_ok),
        .rom_rdata  (rom_rdata)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit en    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic is_f;
        logic killed;
    } ent_t;

    ent_t q[$];
    int   m_starve = 0;

    logic e_space, e_fwin, e_req, e_acc, e_pop, e_fdok, e_ddok;
    logic h_is_f, h_killed;

    // Predict outputs from the current inputs and model state, then compare.
    always @(negedge clk) begin
        h_is_f   = 1'b0;
        h_killed = 1'b0;
        if (q.size() > 0) begin
            h_is_f   = q[0].is_f;
            h_killed = q[0].killed;
        end
        e_space = (q.size() < DEPTH) || rom_data_ok;
        e_fwin  = f_req && (!d_req || (m_starve == STARVE_MAX));
        e_req   = (f_req || d_req) && e_space;
        e_acc   = e_req && rom_addr_ok;
        e_pop   = rom_data_ok && (q.size() > 0);
        e_fdok  = e_pop && h_is_f && !h_killed && !f_cancel;
        e_ddok  = e_pop && !h_is_f;
        if (en) begin
            chk("rom_req",   32'(rom_req),   32'(e_req));
            chk("f_addr_ok", 32'(f_addr_ok), 32'(e_acc && e_fwin));
            chk("d_addr_ok", 32'(d_addr_ok), 32'(e_acc && !e_fwin));
            chk("f_data_ok", 32'(f_data_ok), 32'(e_fdok));
            chk("d_data_ok", 32'(d_data_ok), 32'(e_ddok));
            chk("f_rdata",   f_rdata, rom_rdata);
            chk("d_rdata",   d_rdata, rom_rdata);
            if (e_req) begin
                if (e_fwin) begin
                    chk("rom_addr_f",  rom_addr, f_addr);
                    chk("rom_we_f",    32'(rom_we), 32'd0);
                    chk("rom_wstrb_f", 32'(rom_wstrb), 32'd0);
                end else begin
                    chk("rom_addr_d",  rom_addr, d_addr);
                    chk("rom_we_d",    32'(rom_we), 32'(d_we));
                    chk("rom_wstrb_d", 32'(rom_wstrb), 32'(d_wstrb));
                    chk("rom_wdata_d", rom_wdata, d_wdata);
                end
            end
        end
    end

    // Advance the model state at the clock edge.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_starve = 0;
        end else begin
            if (e_pop)
                void'(q.pop_front());
            if (f_cancel)
                foreach (q[i])
                    if (q[i].is_f)
                        q[i].killed = 1'b1;
            if (e_acc)
                q.push_back('{is_f: e_fwin, killed: e_fwin && f_cancel});
            if (!f_req || (e_acc && e_fwin))
                m_starve = 0;
            else if (e_acc && !e_fwin && m_starve < STARVE_MAX)
                m_starve++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    logic [5:0] pat;

    initial begin
        rst = 1'b1; f_req = 1'b0; f_addr = '0; f_cancel = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_wstrb = 4'h0; d_addr = '0; d_wdata = '0;
        rom_addr_ok = 1'b1; rom_data_ok = 1'b0; rom_rdata = '0;
        tick(); tick();
        rst = 1'b0;
        en  = 1'b1;

        // Reset state: no requests, a stray response produces nothing.
        rom_data_ok = 1'b1; rom_rdata = 32'h1234;
        settle();
        chk("rst_rom_req", 32'(rom_req), 32'd0);
        chk("stray_f_dok", 32'(f_data_ok), 32'd0);
        chk("stray_d_dok", 32'(d_data_ok), 32'd0);
        tick();
        rom_data_ok = 1'b0;

        // Single fetch: accept at 0x80, response 0x13 in the next cycle.
        f_req = 1'b1; f_addr = 32'h80;
        settle();
        chk("t1_f_addr_ok", 32'(f_addr_ok), 32'd1);
        chk("t1_rom_addr",  rom_addr, 32'h80);
        tick();
        f_req = 1'b0; rom_data_ok = 1'b1; rom_rdata = 32'h13;
        settle();
        chk("t1_f_data_ok", 32'(f_data_ok), 32'd1);
        chk("t1_f_rdata",   f_rdata, 32'h13);
        tick();
        rom_data_ok = 1'b0;
        chk("t1_model_empty", 32'(q.size()), 32'd0);

        // Simultaneous requests: data write first, fetch next, in-order routing.
        f_req = 1'b1; f_addr = 32'h84;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
        settle();
        chk("t2_d_addr_ok", 32'(d_addr_ok), 32'd1);
        chk("t2_f_addr_ok", 32'(f_addr_ok), 32'd0);
        chk("t2_rom_we",    32'(rom_we), 32'd1);
        chk("t2_rom_wdata", rom_wdata, 32'hDEADBEEF);
        tick();
        d_req = 1'b0; d_we = 1'b0; d_wstrb = 4'h0;
        settle();
        chk("t2_f_addr_ok2", 32'(f_addr_ok), 32'd1);
        chk("t2_rom_addr",   rom_addr, 32'h84);
        tick();
        f_req = 1'b0; rom_data_ok = 1'b1; rom_rdata = 32'h0;
        settle();
        chk("t2_d_data_ok", 32'(d_data_ok), 32'd1);
        chk("t2_f_quiet",   32'(f_data_ok), 32'd0);
        tick();
        rom_rdata = 32'h99;
        settle();
        chk("t2_f_data_ok", 32'(f_data_ok), 32'd1);
        chk("t2_d_quiet",   32'(d_data_ok), 32'd0);
        tick();
        rom_data_ok = 1'b0;

        // Starvation: d, d, d, d, then f, then d again.
        f_req = 1'b1; f_addr = 32'h88;
        d_req = 1'b1; d_addr = 32'h104;
        rom_data_ok = 1'b1; rom_rdata = 32'h5A;
        pat = 6'b010000;
        for (int i = 0; i < 6; i++) begin
            settle();
            chk("t3_f_grant", 32'(f_addr_ok), 32'(pat[i]));
            chk("t3_d_grant", 32'(d_addr_ok), 32'(!pat[i]));
            tick();
        end
        f_req = 1'b0; d_req = 1'b0;
        settle();
        tick();
        rom_data_ok = 1'b0;
        chk("t3_model_empty", 32'(q.size()), 32'd0);

        // Two fetches outstanding, cancel, both responses dropped.
        f_req = 1'b1; f_addr = 32'h400;
        tick();
        f_addr = 32'h404;
        tick();
        f_req = 1'b0; f_cancel = 1'b1;
        tick();
        f_cancel = 1'b0; rom_data_ok = 1'b1; rom_rdata = 32'hAA;
        settle();
        chk("t4_drop0", 32'(f_data_ok), 32'd0);
        tick();
        settle();
        chk("t4_drop1", 32'(f_data_ok), 32'd0);
        tick();
        rom_data_ok = 1'b0; f_req = 1'b1; f_addr = 32'h200;
        settle();
        chk("t4_new_addr_ok", 32'(f_addr_ok), 32'd1);
        tick();
        f_req = 1'b0; rom_data_ok = 1'b1; rom_rdata = 32'h55;
        settle();
        chk("t4_new_data_ok", 32'(f_data_ok), 32'd1);
        chk("t4_new_rdata",   f_rdata, 32'h55);
        tick();
        rom_data_ok = 1'b0;

        // Cancel leaves data entries alone and drops a head popped the same cycle.
        f_req = 1'b1; f_addr = 32'h208;
        tick();
        f_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        tick();
        d_req = 1'b0; f_cancel = 1'b1; rom_data_ok = 1'b1; rom_rdata = 32'h66;
        settle();
        chk("t4b_head_drop", 32'(f_data_ok), 32'd0);
        tick();
        f_cancel = 1'b0;
        settle();
        chk("t4b_d_survive", 32'(d_data_ok), 32'd1);
        tick();
        rom_data_ok = 1'b0;

        // Full FIFO: stall, then simultaneous pop and push keeps it full.
        f_req = 1'b1; f_addr = 32'h500;
        tick();
        f_addr = 32'h504;
        tick();
        f_addr = 32'h508;
        settle();
        chk("t5_full_req",     32'(rom_req), 32'd0);
        chk("t5_full_addr_ok", 32'(f_addr_ok), 32'd0);
        tick();
        rom_data_ok = 1'b1; rom_rdata = 32'h77;
        settle();
        chk("t5_pp_addr_ok", 32'(f_addr_ok), 32'd1);
        chk("t5_pp_data_ok", 32'(f_data_ok), 32'd1);
        tick();
        rom_data_ok = 1'b0; f_addr = 32'h50C;
        settle();
        chk("t5_still_full", 32'(rom_req), 32'd0);
        tick();
        f_cancel = 1'b1; rom_data_ok = 1'b1;
        settle();
        chk("t5_cancel_pop", 32'(f_data_ok), 32'd0);
        chk("t5_cancel_acc", 32'(f_addr_ok), 32'd1);
        tick();
        f_cancel = 1'b0; f_req = 1'b0;
        settle();
        chk("t5_killed1", 32'(f_data_ok), 32'd0);
        tick();
        settle();
        chk("t5_killed2", 32'(f_data_ok), 32'd0);
        tick();
        rom_data_ok = 1'b0;

        // Reset with two outstanding: later responses are ignored.
        f_req = 1'b1; f_addr = 32'h600;
        tick();
        f_addr = 32'h604;
        tick();
        f_req = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; rom_data_ok = 1'b1; rom_rdata = 32'hBB;
        settle();
        chk("t6_f_dok", 32'(f_data_ok), 32'd0);
        chk("t6_d_dok", 32'(d_data_ok), 32'd0);
        chk("t6_model_empty", 32'(q.size()), 32'd0);
        tick();
        rom_data_ok = 1'b0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
